ysyx_24100027_ifu: RTL

Instruction fetch unit supplying `pc`/`inst` to the single-cycle core. Owns the architectural PC, issues one word-aligned fetch request at a time to instruction memory over a valid/ready request channel, and captures the response. It presents the instruction to the core with a valid/ready handshake. Branch/jump redirects from the core replace the PC and squash any in-flight or held fetch.

---
 rtl/ysyx_24100027_ifu.sv | 117 +++++++++++
 1 files changed

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: owns the architectural PC, fetches one word at a
// time over a valid/ready request channel, and presents pc/inst to the core.
// A redirect replaces the PC and squashes any in-flight or held fetch.
module ysyx_24100027_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        inst_err,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] fetch_pc_r;
    logic [31:0] inst_r;
    logic        inst_err_r;
    logic        drop_r;     // the outstanding response belongs to a squashed fetch
    logic [31:0] redirect_aligned_s;

    // Redirect targets are forced onto a word boundary.
    assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;

    // Outputs come straight from registers or from the state encoding.
    assign imem_req_valid = (state_r == REQ);
    assign imem_req_addr  = fetch_pc_r;
    assign inst_valid     = (state_r == HOLD);
    assign pc             = fetch_pc_r;
    assign inst           = inst_r;
    assign inst_err       = inst_err_r;

    // Fetch sequencer: request, wait for the response, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            inst_r     <= 32'h0000_0000;
            inst_err_r <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= REQ;
                end
                REQ: begin
                    // The address may change while the request is pending.
                    if (redirect_valid) begin
                        fetch_pc_r <= redirect_aligned_s;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                    if (imem_req_ready) begin
                        // Request left with the old address; its reply is stale.
                        state_r <= WAIT;
                        drop_r  <= redirect_valid;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc_r <= redirect_aligned_s;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                    if (imem_resp_valid) begin
                        if (drop_r || redirect_valid) begin
                            drop_r  <= 1'b0;
                            state_r <= REQ;
                        end else begin
                            inst_r     <= imem_resp_data;
                            inst_err_r <= imem_resp_err;
                            state_r    <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop_r <= 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                end
                HOLD: begin
                    // A redirect wins over sequential advance, retired or not.
                    if (redirect_valid) begin
                        fetch_pc_r <= redirect_aligned_s;
                        state_r    <= REQ;
                    end else if (inst_ready) begin
                        fetch_pc_r <= fetch_pc_r + 32'd4;
                        state_r    <= REQ;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
